// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the CPU MEM stage and dmem_responder.
//   master (CPU side) : drives req_i, we_i, addr_i, wdata_i; observes ack_o, rdata_o, stall_o, err_o
//   slave  (responder): the mirror image
// Signal suffixes are named from the responder's point of view.
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory for the CPU MEM stage.
// A request accepted in IDLE waits LATENCY cycles, commits (store writes the
// array, load updates rdata_o), pulses ack_o for one cycle, then returns to IDLE.
// stall_o freezes the pipeline from the request cycle until the ack cycle.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active high
//   bus    - dmem_if.slave: req_i/we_i/addr_i/wdata_i in; ack_o/rdata_o/stall_o/err_o out
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, >= 4)
//   LATENCY - wait-state cycles between accept and commit (1..255)
// Build option:
//   DMEM_MISALIGN_ERR_EN - when defined, accesses with addr_i[1:0] != 0 run the
//   full latency but touch no memory, return rdata_o = 0 and raise err_o with ack_o.
//   When undefined, err_o stays 0 and the low address bits are ignored.
//
// state | meaning
// IDLE  | waiting for req_i; latches the access on acceptance
// WAIT  | counting down wait states; commit on cnt == 0
// RESP  | ack_o high for this one cycle; req_i ignored
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  dmem_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         cnt_q;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               mis_q;
  logic               ack_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem_q [DEPTH];

  logic               mis_d;
  logic               commit;
  logic               mem_wr;

  // Bits above the word index wrap; the low two bits only matter when the
  // misalignment check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  assign mis_d = (bus.addr_i[1:0] != 2'b00);
`else
  assign mis_d = 1'b0;
`endif

  assign commit = (state_q == ST_WAIT) && (cnt_q == 8'd0);
  assign mem_wr = commit && we_q && !mis_q;

  // Array has no reset; gating with rst_i keeps a reset that coincides with the
  // commit edge from writing.
  always_ff @(posedge clk_i) begin
    if (mem_wr && !rst_i) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            idx_q   <= bus.addr_i[IDX_W+1:2];
            wdata_q <= bus.wdata_i;
            mis_q   <= mis_d;
            cnt_q   <= CNT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            ack_q <= 1'b1;
            err_q <= mis_q;
            if (mis_q) begin
              rdata_q <= 32'd0;
            end else if (!we_q) begin
              rdata_q <= mem_q[idx_q];
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;
  assign bus.stall_o = (bus.req_i && (state_q == ST_IDLE)) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=4/DEPTH=256 instance exercised with
// directed and random accesses against an array model, and a LATENCY=1/DEPTH=16
// instance driven with req_i held high for back-to-back accesses.
module tb_dmem_responder;

  localparam int LAT_A   = 4;
  localparam int DEPTH_A = 256;
  localparam int LAT_B   = 1;
  localparam int DEPTH_B = 16;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clk_i (clk_sys),
    .rst_i (rst),
    .bus   (bus_a)
  );

  dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clk_i (clk_sys),
    .rst_i (rst),
    .bus   (bus_b)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks;
  int n_fail;

  logic [31:0] mem_m [DEPTH_A];
  logic [31:0] rdata_m;
  logic [31:0] mem_b [DEPTH_B];
  logic [31:0] rdata_b;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  bit          r_scr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge with dut_a idle; returns just after a
  // falling edge with dut_a idle again.
  task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int abort_at, input bit rst_resp, input bit scramble);
    int          idx;
    bit          mis;
    logic [31:0] exp_rd;
    idx = int'((addr >> 2) % 32'(DEPTH_A));
    mis = MIS_EN && (addr[1:0] != 2'b00);
    if (mis)     exp_rd = 32'h0;
    else if (we) exp_rd = rdata_m;
    else         exp_rd = mem_m[idx];

    bus_a.req_i   = 1'b1;
    bus_a.we_i    = we;
    bus_a.addr_i  = addr;
    bus_a.wdata_i = wdata;
    #1;
    check("a_stall_accept", 32'(bus_a.stall_o), 32'd1);
    check("a_ack_accept",   32'(bus_a.ack_o),   32'd0);

    for (int k = 1; k <= LAT_A + 1; k++) begin
      @(negedge clk_sys);
      if (abort_at == k) begin
        bus_a.req_i = 1'b0;
        rst = 1'b1;
        #1;
        check("a_abort_ack",   32'(bus_a.ack_o),   32'd0);
        check("a_abort_stall", 32'(bus_a.stall_o), 32'd0);
        check("a_abort_rdata", bus_a.rdata_o,      32'd0);
        check("a_abort_err",   32'(bus_a.err_o),   32'd0);
        rdata_m = 32'h0;
        @(negedge clk_sys);
        rst = 1'b0;
        return;
      end
      if (k <= LAT_A) begin
        check("a_wait_stall", 32'(bus_a.stall_o), 32'd1);
        check("a_wait_ack",   32'(bus_a.ack_o),   32'd0);
        if (scramble) begin
          bus_a.we_i    = 1'($urandom_range(0, 1));
          bus_a.addr_i  = $urandom;
          bus_a.wdata_i = $urandom;
        end
      end else begin
        check("a_ack",       32'(bus_a.ack_o),   32'd1);
        check("a_ack_stall", 32'(bus_a.stall_o), 32'd0);
        check("a_rdata",     bus_a.rdata_o,      exp_rd);
        check("a_err",       32'(bus_a.err_o),   32'(mis));
        if (!mis && we) mem_m[idx] = wdata;
        rdata_m = exp_rd;
        bus_a.req_i = 1'b0;
        if (rst_resp) begin
          rst = 1'b1;
          #1;
          check("a_resp_rst_ack",   32'(bus_a.ack_o), 32'd0);
          check("a_resp_rst_rdata", bus_a.rdata_o,    32'd0);
          rdata_m = 32'h0;
          @(negedge clk_sys);
          rst = 1'b0;
          return;
        end
      end
    end
    @(negedge clk_sys);
    check("a_post_ack",   32'(bus_a.ack_o),   32'd0);
    check("a_post_stall", 32'(bus_a.stall_o), 32'd0);
    check("a_post_rdata", bus_a.rdata_o,      rdata_m);
    check("a_post_err",   32'(bus_a.err_o),   32'd0);
  endtask

  // Six accesses on dut_b with req_i never dropped: one ack every LAT_B+2 cycles.
  task automatic run_b();
    logic [31:0] b_addr [6];
    logic        b_we   [6];
    logic [31:0] b_wd   [6];
    logic [31:0] exp_rd;
    int          op;
    int          idx;
    b_addr = '{32'h04, 32'h08, 32'h4C, 32'h44, 32'h08, 32'h0C};
    b_we   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) b_wd[i] = $urandom;
    op = 0;
    bus_b.req_i   = 1'b1;
    bus_b.we_i    = b_we[0];
    bus_b.addr_i  = b_addr[0];
    bus_b.wdata_i = b_wd[0];
    for (int k = 0; k < 6 * (LAT_B + 2); k++) begin
      if (k > 0) @(negedge clk_sys);
      #1;
      check("b_ack",   32'(bus_b.ack_o),   32'((k % 3) == 2));
      check("b_stall", 32'(bus_b.stall_o), 32'((k % 3) != 2));
      if ((k % 3) == 2) begin
        idx = int'((b_addr[op] >> 2) % 32'(DEPTH_B));
        if (b_we[op]) begin
          mem_b[idx] = b_wd[op];
          exp_rd = rdata_b;
        end else begin
          exp_rd = mem_b[idx];
        end
        rdata_b = exp_rd;
        check("b_rdata", bus_b.rdata_o, exp_rd);
        op++;
        if (op < 6) begin
          bus_b.we_i    = b_we[op];
          bus_b.addr_i  = b_addr[op];
          bus_b.wdata_i = b_wd[op];
        end else begin
          bus_b.req_i = 1'b0;
        end
      end
    end
    @(negedge clk_sys);
    check("b_idle_ack", 32'(bus_b.ack_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rdata_m  = 32'h0;
    rdata_b  = 32'h0;
    rst      = 1'b1;
    bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = 32'h0; bus_a.wdata_i = 32'h0;
    bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = 32'h0; bus_b.wdata_i = 32'h0;

    #2;
    check("rst_ack",   32'(bus_a.ack_o),   32'd0);
    check("rst_rdata", bus_a.rdata_o,      32'd0);
    check("rst_err",   32'(bus_a.err_o),   32'd0);
    check("rst_stall", 32'(bus_a.stall_o), 32'd0);
    check("rst_ack_b", 32'(bus_b.ack_o),   32'd0);
    bus_a.req_i = 1'b1;
    #1;
    check("rst_stall_req", 32'(bus_a.stall_o), 32'd1);
    bus_a.req_i = 1'b0;
    #1;
    check("rst_stall_noreq", 32'(bus_a.stall_o), 32'd0);

    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;

    run_b();

    for (int i = 0; i < DEPTH_A; i++) begin
      access_a(1'b1, 32'(i * 4), (i == 8) ? 32'h0000_AAAA : $urandom, 0, 1'b0, 1'b0);
    end

    access_a(1'b1, 32'h10,  32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    access_a(1'b0, 32'h10,  32'h0,         0, 1'b0, 1'b0);
    access_a(1'b1, 32'h400, 32'h1,         0, 1'b0, 1'b0);
    access_a(1'b0, 32'h0,   32'h0,         0, 1'b0, 1'b0);
    access_a(1'b1, 32'h20,  32'h55,        2, 1'b0, 1'b0);
    access_a(1'b0, 32'h20,  32'h0,         0, 1'b0, 1'b0);
    access_a(1'b1, 32'h13,  32'h1234_5678, 0, 1'b0, 1'b0);
    access_a(1'b0, 32'h10,  32'h0,         0, 1'b0, 1'b0);
    access_a(1'b0, 32'h400, 32'h0,         0, 1'b1, 1'b0);
    access_a(1'b0, 32'hFFFF_FC04, 32'h0,   0, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_scr   = ($urandom_range(0, 3) == 0);
      access_a(r_we, r_addr, r_wdata, 0, 1'b0, r_scr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule
